// File: rtl/pipe_stage_skid_reg.sv
// Parametrised valid/ready pipeline stage register with optional 2-entry skid
// buffer, synchronous flush and zeroed bubbles.
module pipe_stage_skid_reg #(
    parameter int unsigned DATA_W      = 105,
    parameter bit          SKID        = 1'b1,
    parameter bit          ZERO_BUBBLE = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    logic              r_m_valid;
    logic [DATA_W-1:0] r_m_data;
    logic              r_s_valid;
    logic              w_accept;
    logic              w_drain;

    assign w_accept = in_valid & in_ready;
    assign w_drain  = r_m_valid & out_ready;

    generate
        if (SKID) begin : g_skid
            logic [DATA_W-1:0] r_s_data;

            // in_ready depends only on the skid flag, so no path from out_ready
            assign in_ready = ~r_s_valid;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_m_valid <= 1'b0;
                    r_m_data  <= '0;
                    r_s_valid <= 1'b0;
                    r_s_data  <= '0;
                end else if (flush) begin
                    r_m_valid <= 1'b0;
                    r_s_valid <= 1'b0;
                end else if (!r_m_valid || w_drain) begin
                    if (r_s_valid) begin
                        r_m_valid <= 1'b1;
                        r_m_data  <= r_s_data;
                        r_s_valid <= 1'b0;
                    end else if (w_accept) begin
                        r_m_valid <= 1'b1;
                        r_m_data  <= in_data;
                    end else begin
                        r_m_valid <= 1'b0;
                    end
                end else if (w_accept) begin
                    r_s_valid <= 1'b1;
                    r_s_data  <= in_data;
                end
            end
        end else begin : g_single
            assign in_ready  = ~r_m_valid | out_ready;
            assign r_s_valid = 1'b0;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_m_valid <= 1'b0;
                    r_m_data  <= '0;
                end else if (flush) begin
                    r_m_valid <= 1'b0;
                end else if (w_accept) begin
                    r_m_valid <= 1'b1;
                    r_m_data  <= in_data;
                end else if (w_drain) begin
                    r_m_valid <= 1'b0;
                end
            end
        end
    endgenerate

    assign out_valid = r_m_valid;
    assign occupancy = 2'(r_m_valid) + 2'(r_s_valid);

    always_comb begin
        out_data = r_m_data;
        if (ZERO_BUBBLE && !r_m_valid) begin
            out_data = '0;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Self-checking bench: vector table plus FIFO scoreboard for the skid and
// single-entry variants, and hand sequences for reset and bubble corner cases.
module tb_pipe_stage_skid_reg;

    localparam int unsigned W = 105;

    logic         clk;
    logic         reset;

    // SKID=1, ZERO_BUBBLE=1
    logic         flush, iv, ir, ov, ordy;
    logic [W-1:0] din, dout;
    logic [1:0]   occ;
    // SKID=0, ZERO_BUBBLE=1
    logic         flush0, iv0, ir0, ov0, ordy0;
    logic [W-1:0] din0, dout0;
    logic [1:0]   occ0;
    // SKID=1, ZERO_BUBBLE=0
    logic         ivz, irz, ovz, ordyz;
    logic [W-1:0] dinz, doutz;
    logic [1:0]   occz;

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] q_main[$];
    logic [W-1:0] q_one[$];

    pipe_stage_skid_reg #(.DATA_W(W), .SKID(1'b1), .ZERO_BUBBLE(1'b1)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(iv), .in_ready(ir),
        .in_data(din), .out_valid(ov), .out_ready(ordy), .out_data(dout), .occupancy(occ)
    );

    pipe_stage_skid_reg #(.DATA_W(W), .SKID(1'b0), .ZERO_BUBBLE(1'b1)) dut0 (
        .clk(clk), .reset(reset), .flush(flush0), .in_valid(iv0), .in_ready(ir0),
        .in_data(din0), .out_valid(ov0), .out_ready(ordy0), .out_data(dout0), .occupancy(occ0)
    );

    pipe_stage_skid_reg #(.DATA_W(W), .SKID(1'b1), .ZERO_BUBBLE(1'b0)) dutz (
        .clk(clk), .reset(reset), .flush(1'b0), .in_valid(ivz), .in_ready(irz),
        .in_data(dinz), .out_valid(ovz), .out_ready(ordyz), .out_data(doutz), .occupancy(occz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic underflow(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s actual=output_valid required=no_pending_payload at %0t", name, $time);
    endtask

    // Scoreboards: pop on drain first, then a flush kills everything held,
    // otherwise an accepted payload is queued.
    always @(posedge clk) begin
        if (reset) begin
            if (ov && ordy) begin
                if (q_main.size() == 0) underflow("sb_main_underflow");
                else chk("sb_main_data", 128'(dout), 128'(q_main.pop_front()));
            end
            if (flush) q_main.delete();
            else if (iv && ir) q_main.push_back(din);

            if (ov0 && ordy0) begin
                if (q_one.size() == 0) underflow("sb_one_underflow");
                else chk("sb_one_data", 128'(dout0), 128'(q_one.pop_front()));
            end
            if (flush0) q_one.delete();
            else if (iv0 && ir0) q_one.push_back(din0);
        end
    end

    typedef struct {
        logic        fl;
        logic        iv;
        logic        ordy;
        logic [31:0] d;
        logic        e_ov;
        logic [31:0] e_od;
        logic [1:0]  e_occ;
        logic        e_ir;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic fl, input logic v, input logic r, input logic [31:0] d,
                       input logic e_ov, input logic [31:0] e_od, input logic [1:0] e_occ,
                       input logic e_ir);
        vec_t t;
        t.fl = fl; t.iv = v; t.ordy = r; t.d = d;
        t.e_ov = e_ov; t.e_od = e_od; t.e_occ = e_occ; t.e_ir = e_ir;
        tbl.push_back(t);
    endtask

    function automatic logic [W-1:0] rnd_data();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r[W-1:0];
    endfunction

    initial begin
        reset = 1'b0;
        flush = 1'b0; iv = 1'b0; ordy = 1'b0; din = '0;
        flush0 = 1'b0; iv0 = 1'b0; ordy0 = 1'b0; din0 = '0;
        ivz = 1'b0; ordyz = 1'b0; dinz = '0;

        // streaming 1..4 with downstream ready
        add(1'b0, 1'b1, 1'b1, 32'h1,  1'b1, 32'h1, 2'd1, 1'b1);
        add(1'b0, 1'b1, 1'b1, 32'h2,  1'b1, 32'h2, 2'd1, 1'b1);
        add(1'b0, 1'b1, 1'b1, 32'h3,  1'b1, 32'h3, 2'd1, 1'b1);
        add(1'b0, 1'b1, 1'b1, 32'h4,  1'b1, 32'h4, 2'd1, 1'b1);
        add(1'b0, 1'b0, 1'b1, 32'h0,  1'b0, 32'h0, 2'd0, 1'b1);
        // stall into skid, hold, then drain A then B
        add(1'b0, 1'b1, 1'b0, 32'hA,  1'b1, 32'hA, 2'd1, 1'b1);
        add(1'b0, 1'b1, 1'b0, 32'hB,  1'b1, 32'hA, 2'd2, 1'b0);
        add(1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'hA, 2'd2, 1'b0);
        add(1'b0, 1'b0, 1'b1, 32'h0,  1'b1, 32'hB, 2'd1, 1'b1);
        add(1'b0, 1'b0, 1'b1, 32'h0,  1'b0, 32'h0, 2'd0, 1'b1);
        // flush with both entries full while C is offered
        add(1'b0, 1'b1, 1'b0, 32'hA,  1'b1, 32'hA, 2'd1, 1'b1);
        add(1'b0, 1'b1, 1'b0, 32'hB,  1'b1, 32'hA, 2'd2, 1'b0);
        add(1'b1, 1'b1, 1'b0, 32'hC,  1'b0, 32'h0, 2'd0, 1'b1);
        add(1'b0, 1'b0, 1'b1, 32'h0,  1'b0, 32'h0, 2'd0, 1'b1);
        // flush discards a payload that is actually accepted
        add(1'b1, 1'b1, 1'b1, 32'hD,  1'b0, 32'h0, 2'd0, 1'b1);
        add(1'b0, 1'b0, 1'b1, 32'h0,  1'b0, 32'h0, 2'd0, 1'b1);
        // upstream holding 13 while the skid entry moves forward first
        add(1'b0, 1'b1, 1'b0, 32'h11, 1'b1, 32'h11, 2'd1, 1'b1);
        add(1'b0, 1'b1, 1'b0, 32'h12, 1'b1, 32'h11, 2'd2, 1'b0);
        add(1'b0, 1'b1, 1'b1, 32'h13, 1'b1, 32'h12, 2'd1, 1'b1);
        add(1'b0, 1'b1, 1'b1, 32'h13, 1'b1, 32'h13, 2'd1, 1'b1);
        add(1'b0, 1'b0, 1'b1, 32'h0,  1'b0, 32'h0, 2'd0, 1'b1);

        // reset held for 3 cycles
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rst_out_valid", 128'(ov), 128'(0));
            chk("rst_out_data",  128'(dout), 128'(0));
            chk("rst_occupancy", 128'(occ), 128'(0));
            chk("rst_in_ready",  128'(ir), 128'(1));
        end
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            flush = tbl[i].fl; iv = tbl[i].iv; ordy = tbl[i].ordy; din = W'(tbl[i].d);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_out_valid", i), 128'(ov),   128'(tbl[i].e_ov));
            chk($sformatf("vec%0d_out_data", i),  128'(dout), 128'(tbl[i].e_od));
            chk($sformatf("vec%0d_occupancy", i), 128'(occ),  128'(tbl[i].e_occ));
            chk($sformatf("vec%0d_in_ready", i),  128'(ir),   128'(tbl[i].e_ir));
        end

        // random traffic on both variants, checked by the scoreboards
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            iv  = 1'($urandom_range(0, 1)); din  = rnd_data();
            ordy = ($urandom_range(0, 3) != 0); flush = ($urandom_range(0, 15) == 0);
            iv0 = 1'($urandom_range(0, 1)); din0 = rnd_data();
            ordy0 = ($urandom_range(0, 3) != 0); flush0 = ($urandom_range(0, 15) == 0);
        end
        @(negedge clk);
        iv = 1'b0; ordy = 1'b1; flush = 1'b0;
        iv0 = 1'b0; ordy0 = 1'b1; flush0 = 1'b0;
        repeat (3) @(negedge clk);
        chk("sb_main_left", 128'(q_main.size()), 128'(0));
        chk("sb_one_left",  128'(q_one.size()),  128'(0));
        chk("drain_main_valid", 128'(ov), 128'(0));

        // single-entry stall: in_ready follows out_ready combinationally
        iv0 = 1'b1; din0 = W'(32'h5); ordy0 = 1'b1;
        @(negedge clk);
        ordy0 = 1'b0; din0 = W'(32'h9);
        #1 chk("one_stall_in_ready", 128'(ir0), 128'(0));
        @(posedge clk); #1;
        chk("one_hold_data",  128'(dout0), 128'(32'h5));
        chk("one_hold_valid", 128'(ov0), 128'(1));
        chk("one_occupancy",  128'(occ0), 128'(1));
        @(negedge clk);
        ordy0 = 1'b1; din0 = W'(32'h6);
        #1 chk("one_release_in_ready", 128'(ir0), 128'(1));
        @(posedge clk); #1;
        chk("one_next_data", 128'(dout0), 128'(32'h6));
        @(negedge clk);
        iv0 = 1'b0;
        @(posedge clk); #1;
        chk("one_empty_valid", 128'(ov0), 128'(0));
        chk("one_empty_data",  128'(dout0), 128'(0));
        chk("one_empty_occ",   128'(occ0), 128'(0));

        // asynchronous reset with both skid entries full
        @(negedge clk);
        iv = 1'b1; din = W'(32'hA); ordy = 1'b0;
        @(negedge clk);
        din = W'(32'hB);
        @(negedge clk);
        iv = 1'b0;
        chk("areset_pre_occ", 128'(occ), 128'(2));
        #2 reset = 1'b0;
        #1;
        chk("areset_out_valid", 128'(ov), 128'(0));
        chk("areset_occupancy", 128'(occ), 128'(0));
        chk("areset_out_data",  128'(dout), 128'(0));
        chk("areset_in_ready",  128'(ir), 128'(1));
        @(negedge clk);
        q_main.delete();
        q_one.delete();
        reset = 1'b1;
        ordy = 1'b1;
        @(posedge clk); #1;
        chk("areset_after_valid", 128'(ov), 128'(0));

        // ZERO_BUBBLE=0 keeps the last payload visible once drained
        @(negedge clk);
        ivz = 1'b1; dinz = W'(32'h7); ordyz = 1'b1;
        @(posedge clk); #1;
        chk("nzb_valid", 128'(ovz), 128'(1));
        chk("nzb_data",  128'(doutz), 128'(32'h7));
        @(negedge clk);
        ivz = 1'b0;
        @(posedge clk); #1;
        chk("nzb_bubble_valid", 128'(ovz), 128'(0));
        chk("nzb_bubble_data",  128'(doutz), 128'(32'h7));
        chk("nzb_bubble_occ",   128'(occz), 128'(0));

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
